// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter
// Picks one reservation-station requester per cycle and issues it into a
// two-stage pipeline: an issue register (ISS) that feeds the combinational
// arithmetic unit, then a result register (RES) that drives the CDB.
//
// Arbitration: round-robin by default. The pointer holds the highest-priority
// requester and moves to one past the winner after each grant. Defining the
// macro ALU_ARB_FIXED_PRIO_EN selects fixed priority instead: the lowest-index
// valid requester always wins, and there is no pointer register.
//
// Handshakes (strict valid/ready): a requester transfers on the rising edge
// where req_valid_i[i] and req_ready_o[i] are both high. req_ready_o is
// combinational and does not depend on req_ready_o itself. The CDB transfer
// completes on the edge where cdb_valid_o and cdb_ready_i are both high.
// While cdb_valid_o is high and cdb_ready_i is low, the result is held stable.
//
// Ports:
//   clk_i, reset_i (sync, active-low), flush_i (sync, clears both stages)
//   req_valid_i/req_ready_o : per-requester issue handshake
//   req_pc_i, req_inst_i, req_rs1_i, req_rs2_i (32b slices), req_tag_i (TAG_W slices)
//   alu_request_o, pc_o, inst_o, rs1_value_o, rs2_value_o : ISS contents to the ALU
//   alu_wb_valid_i, alu_wb_value_i : ALU result in the same cycle
//   cdb_valid_o, cdb_tag_o, cdb_value_o, cdb_ready_i : result toward the CDB
module alu_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic [NUM_REQ*32-1:0]    req_pc_i,
    input  logic [NUM_REQ*32-1:0]    req_inst_i,
    input  logic [NUM_REQ*32-1:0]    req_rs1_i,
    input  logic [NUM_REQ*32-1:0]    req_rs2_i,
    input  logic [NUM_REQ*TAG_W-1:0] req_tag_i,
    output logic                     alu_request_o,
    output logic [31:0]              pc_o,
    output logic [31:0]              inst_o,
    output logic [31:0]              rs1_value_o,
    output logic [31:0]              rs2_value_o,
    input  logic                     alu_wb_valid_i,
    input  logic [31:0]              alu_wb_value_i,
    output logic                     cdb_valid_o,
    output logic [TAG_W-1:0]         cdb_tag_o,
    output logic [31:0]              cdb_value_o,
    input  logic                     cdb_ready_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic              iss_valid_q, iss_valid_d;
    logic [31:0]       iss_pc_q, iss_pc_d;
    logic [31:0]       iss_inst_q, iss_inst_d;
    logic [31:0]       iss_rs1_q, iss_rs1_d;
    logic [31:0]       iss_rs2_q, iss_rs2_d;
    logic [TAG_W-1:0]  iss_tag_q, iss_tag_d;
    logic              res_valid_q, res_valid_d;
    logic [TAG_W-1:0]  res_tag_q, res_tag_d;
    logic [31:0]       res_value_q, res_value_d;

    logic              res_load;
    logic              iss_adv;
    logic              iss_open;
    logic              grant_found;
    logic              grant_en;
    logic [PTR_W-1:0]  grant_idx;
    logic [31:0]       sel_pc, sel_inst, sel_rs1, sel_rs2;
    logic [TAG_W-1:0]  sel_tag;

    // RES refills in the same cycle it drains; ISS can take a new entry in
    // the same cycle its current entry moves into RES.
    assign res_load = !res_valid_q || cdb_ready_i;
    assign iss_adv  = iss_valid_q && res_load;
    assign iss_open = !iss_valid_q || iss_adv;
    assign grant_en = reset_i && !flush_i && iss_open && grant_found;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(k);
            end
        end
    end
`else
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // Search ptr, ptr+1, ... wrapping at NUM_REQ; first valid wins.
    always_comb begin
        logic [PTR_W:0] sum;
        grant_found = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_REQ)) begin
                sum = sum - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid_i[sum[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = sum[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_en) begin
            if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        req_ready_o = '0;
        if (grant_en) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        sel_pc   = '0;
        sel_inst = '0;
        sel_rs1  = '0;
        sel_rs2  = '0;
        sel_tag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_pc   = req_pc_i[32*i +: 32];
                sel_inst = req_inst_i[32*i +: 32];
                sel_rs1  = req_rs1_i[32*i +: 32];
                sel_rs2  = req_rs2_i[32*i +: 32];
                sel_tag  = req_tag_i[TAG_W*i +: TAG_W];
            end
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_pc_d    = iss_pc_q;
        iss_inst_d  = iss_inst_q;
        iss_rs1_d   = iss_rs1_q;
        iss_rs2_d   = iss_rs2_q;
        iss_tag_d   = iss_tag_q;
        res_valid_d = res_valid_q;
        res_tag_d   = res_tag_q;
        res_value_d = res_value_q;
        if (flush_i) begin
            iss_valid_d = 1'b0;
            res_valid_d = 1'b0;
        end else begin
            if (res_load) begin
                // A dropped ALU writeback leaves RES empty.
                res_valid_d = iss_adv && alu_wb_valid_i;
                if (iss_adv) begin
                    res_tag_d   = iss_tag_q;
                    res_value_d = alu_wb_value_i;
                end
            end
            if (grant_en) begin
                iss_valid_d = 1'b1;
                iss_pc_d    = sel_pc;
                iss_inst_d  = sel_inst;
                iss_rs1_d   = sel_rs1;
                iss_rs2_d   = sel_rs2;
                iss_tag_d   = sel_tag;
            end else if (iss_adv) begin
                iss_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            iss_valid_q <= 1'b0;
            iss_pc_q    <= '0;
            iss_inst_q  <= '0;
            iss_rs1_q   <= '0;
            iss_rs2_q   <= '0;
            iss_tag_q   <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_value_q <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_pc_q    <= iss_pc_d;
            iss_inst_q  <= iss_inst_d;
            iss_rs1_q   <= iss_rs1_d;
            iss_rs2_q   <= iss_rs2_d;
            iss_tag_q   <= iss_tag_d;
            res_valid_q <= res_valid_d;
            res_tag_q   <= res_tag_d;
            res_value_q <= res_value_d;
        end
    end

    // Outputs are forced to zero while reset is asserted so they are clean
    // even before the first reset edge. ISS data reads zero when empty.
    assign alu_request_o = reset_i && iss_valid_q;
    assign pc_o          = alu_request_o ? iss_pc_q   : '0;
    assign inst_o        = alu_request_o ? iss_inst_q : '0;
    assign rs1_value_o   = alu_request_o ? iss_rs1_q  : '0;
    assign rs2_value_o   = alu_request_o ? iss_rs2_q  : '0;
    assign cdb_valid_o   = reset_i && res_valid_q;
    assign cdb_tag_o     = reset_i ? res_tag_q   : '0;
    assign cdb_value_o   = reset_i ? res_value_q : '0;

endmodule

// File: doc/alu_issue_arbiter.md
ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of reservation-station requesters, 2..8.
REQ-002 Parameter TAG_W, default 4: width of the destination ROB tag.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  reset, synchronous and active-low.
REQ-005 flush_i  input  1  pipeline flush (branch mispredict); synchronous.
REQ-006 req_valid_i  input  NUM_REQ  per-requester ready-to-issue flag.
REQ-007 req_ready_o  output  NUM_REQ  per-requester accept strobe; at most one bit high.
REQ-008 req_pc_i  input  NUM_REQ*32  packed PC per requester; slice i = bits [32*i+31:32*i].
REQ-009 req_inst_i  input  NUM_REQ*32  packed instruction word per requester.
REQ-010 req_rs1_i, req_rs2_i  input  NUM_REQ*32 each  packed operand values.
REQ-011 req_tag_i  input  NUM_REQ*TAG_W  packed destination tag.
REQ-012 alu_request_o  output  1  drives the arithmetic unit request.
REQ-013 pc_o, inst_o, rs1_value_o, rs2_value_o  output  32 each  issue-register contents to the arithmetic unit.
REQ-014 alu_wb_valid_i  input  1  arithmetic unit writeback valid (same cycle as request).
REQ-015 alu_wb_value_i  input  32  arithmetic unit result.
REQ-016 cdb_valid_o  output  1  result valid toward common data bus.
REQ-017 cdb_tag_o  output  TAG_W  tag of the result.
REQ-018 cdb_value_o  output  32  result value.
REQ-019 cdb_ready_i  input  1  CDB accepts the result this cycle.

Function
REQ-020 Two-stage pipeline: issue register (ISS) feeding the combinational arithmetic unit, then result register (RES) driving the CDB; each stage holds a valid bit.
REQ-021 RES shall load when empty or when cdb_valid_o and cdb_ready_i are both high (drain-and-refill same cycle).
REQ-022 ISS advances into RES when ISS valid and RES loads; RES captures alu_wb_value_i and the ISS tag; if alu_wb_valid_i is low on advance, RES valid stays low.
REQ-023 ISS can accept when empty or advancing; grant occurs only then and only if some req_valid_i is high.
REQ-024 req_ready_o[i] is combinational, high only for the granted requester; request i is consumed on the edge where req_valid_i[i] and req_ready_o[i] are both high.
REQ-025 Round-robin: pointer P (reset 0) marks highest priority; search P, P+1, ... modulo NUM_REQ; after grant to i, P becomes (i+1) mod NUM_REQ; P unchanged with no grant.
REQ-026 Latency: request accepted at edge N -> alu_request_o high in cycle N+1 -> cdb_valid_o high in cycle N+2 with no backpressure; throughput one per cycle.
REQ-027 Backpressure: with cdb_ready_i low and RES valid, RES and cdb outputs hold stable; ISS holds; req_ready_o all low.
REQ-028 alu_request_o equals ISS valid; pc_o/inst_o/rs1_value_o/rs2_value_o hold ISS contents, zero when ISS empty.
REQ-029 flush_i high: ISS and RES valid cleared next edge, no grant that cycle (req_ready_o all low), P unchanged; flush has priority over advance and accept.

Reset
REQ-030 reset_i low at an edge: ISS valid, RES valid, P cleared; all data registers zero; reset overrides flush and all handshakes, including mid-operation.
REQ-031 While reset_i low: req_ready_o, alu_request_o, cdb_valid_o all 0; cdb_tag_o, cdb_value_o, pc_o, inst_o, rs1_value_o, rs2_value_o all 0.

Configuration
REQ-032 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, lowest-index valid requester always wins, P not implemented.
REQ-033 Macro undefined: round-robin per REQ-025.

Verification
REQ-034 Reset low 2 cycles, then high, no requests -> all outputs 0, P=0.
REQ-035 req_valid_i=4'b1111 held 4 cycles, cdb_ready_i=1 -> grants 0,1,2,3 in order; cdb_valid_o one per cycle from 2 cycles after first grant.
REQ-036 Requester 2: ADDI x,x,5 with rs1=10, tag=3 -> cycle N+2: cdb_valid_o=1, cdb_tag_o=3, cdb_value_o=15.
REQ-037 Two back-to-back requests, cdb_ready_i=0 for 3 cycles -> RES holds first result unchanged, ISS holds second, req_ready_o=0; on release both drain on consecutive cycles.
REQ-038 flush_i pulsed with ISS and RES valid -> next cycle alu_request_o=0, cdb_valid_o=0, no grant in flush cycle, P unchanged.
REQ-039 With ALU_ARB_FIXED_PRIO_EN, req_valid_i=4'b0110 held -> requester 1 granted every cycle, requester 2 starved.
